sysid_checker: RTL and testbench



---
 rtl/sysid_checker_pkg.sv | 44 ++++
 rtl/sysid_read_timer.sv | 46 ++++
 rtl/sysid_checker.sv | 199 +++++++++++++++++++
 tb/tb_sysid_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// -----------------------------------------------------------------------------
// sysid_checker_pkg
// Shared types and constants for the system ID boot checker:
//   - state_e          : checker FSM states
//   - SYSID_ADDR_*     : word addresses of the ID and timestamp registers
//   - ERR_CNT_W/MAX    : mismatch counter width and saturation value
//   - TS_CHECK_EN      : 1 when the timestamp check is built in
//   - timer_width()    : read-wait counter width for a given slave latency
//   - sat_inc()        : saturating increment of the mismatch counter
// Optional feature macro: SYSID_CHECKER_TS_CHECK_EN (timestamp read/compare).
// -----------------------------------------------------------------------------
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int unsigned      ERR_CNT_W   = 32'd8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

`ifdef SYSID_CHECKER_TS_CHECK_EN
    localparam bit TS_CHECK_EN = 1'b1;
`else
    localparam bit TS_CHECK_EN = 1'b0;
`endif

    // Counter must hold READ_LATENCY; a zero-latency slave still needs one bit.
    function automatic int unsigned timer_width(input int unsigned lat);
        return (lat == 32'd0) ? 32'd1 : 32'($clog2(lat + 32'd1));
    endfunction

    // Mismatch counter sticks at its maximum instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/sysid_read_timer.sv
// -----------------------------------------------------------------------------
// sysid_read_timer
// Loadable down-counter that marks the last cycle of a slave read phase.
// Ports:
//   clock    in  clock, rising edge
//   reset_n  in  synchronous reset, active low
//   load_i   in  reload the counter with LOAD_VAL (asserted on read-phase entry)
//   last_o   out high while the counter has reached zero (capture cycle)
// -----------------------------------------------------------------------------
module sysid_read_timer #(
    parameter int unsigned LOAD_VAL = 0,
    parameter int unsigned CNT_W    = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on phase entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
// Boot-time consumer of the system ID peripheral's Avalon-MM slave. On start it
// reads the ID word (address 0) and, when built with SYSID_CHECKER_TS_CHECK_EN,
// the build timestamp (address 1), compares them to EXPECTED_ID/EXPECTED_TS and
// reports pass/fail plus a saturating mismatch count.
// Without SYSID_CHECKER_TS_CHECK_EN the timestamp phase is skipped, ts_value
// stays 0 and ts_ok reports 1 after every check.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   start                   one-cycle request, dropped while busy or in DONE
//   sysid_address/read      registered slave address and read strobe
//   sysid_readdata          slave read data
//   busy                    check in progress (excludes the DONE cycle)
//   done                    one-cycle pulse, results valid
//   id_ok, ts_ok            match flags, held until the next done
//   id_value, ts_value      captured words
//   err_count               checks with any mismatch, saturates at 255
// -----------------------------------------------------------------------------
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1520001003,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 sysid_address,
    output logic                 sysid_read,
    input  logic [31:0]          sysid_readdata,
    output logic                 busy,
    output logic                 done,
    output logic                 id_ok,
    output logic                 ts_ok,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CNT_W = timer_width(READ_LATENCY);

    state_e                 state_q, state_d;
    logic                   addr_q, addr_d;
    logic                   read_q, read_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   id_ok_q, id_ok_d;
    logic                   ts_ok_q, ts_ok_d;
    logic [31:0]            id_value_q, id_value_d;
    logic [31:0]            ts_value_q, ts_value_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic                   last_s;
    logic                   load_s;
    logic                   id_match_s;
    logic                   ts_match_s;

    // Reload on entry to a read phase only, so the count spans the whole phase.
    assign load_s = read_d && (state_d != state_q);

    sysid_read_timer #(
        .LOAD_VAL (READ_LATENCY),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (load_s),
        .last_o  (last_s)
    );

    assign id_match_s = (id_value_q == EXPECTED_ID);
    // Without the timestamp phase the flag is reported as matching.
    assign ts_match_s = (ts_value_q == EXPECTED_TS) || !TS_CHECK_EN;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD_ID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ID: begin
                if (last_s) begin
`ifdef SYSID_CHECKER_TS_CHECK_EN
                    state_d = ST_RD_TS;
`else
                    state_d = ST_CMP;
`endif
                end else begin
                    state_d = ST_RD_ID;
                end
            end
            ST_RD_TS: begin
`ifdef SYSID_CHECKER_TS_CHECK_EN
                if (last_s) begin
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_RD_TS;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_CMP:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        read_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
        addr_d = (state_d == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS) || (state_d == ST_CMP);
        done_d = (state_d == ST_DONE);
    end

    // Capture and compare datapath.
    always_comb begin
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;
        id_ok_d     = id_ok_q;
        ts_ok_d     = ts_ok_q;
        err_count_d = err_count_q;

        if ((state_q == ST_RD_ID) && last_s) begin
            id_value_d = sysid_readdata;
        end else begin
            id_value_d = id_value_q;
        end

`ifdef SYSID_CHECKER_TS_CHECK_EN
        if ((state_q == ST_RD_TS) && last_s) begin
            ts_value_d = sysid_readdata;
        end else begin
            ts_value_d = ts_value_q;
        end
`else
        ts_value_d = 32'd0;
`endif

        if (state_q == ST_CMP) begin
            id_ok_d = id_match_s;
            ts_ok_d = ts_match_s;
            if (!id_match_s || !ts_match_s) begin
                err_count_d = sat_inc(err_count_q);
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            id_ok_d = id_ok_q;
            ts_ok_d = ts_ok_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 1'b0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            id_value_q  <= 32'd0;
            ts_value_q  <= 32'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            id_ok_q     <= id_ok_d;
            ts_ok_q     <= ts_ok_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
            err_count_q <= err_count_d;
        end
    end

    assign sysid_address = addr_q;
    assign sysid_read    = read_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign id_value      = id_value_q;
    assign ts_value      = ts_value_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_sysid_checker
// Two checker instances: dut0 (READ_LATENCY=0, combinational slave model) and
// dut2 (READ_LATENCY=2, slave model delays data two cycles). Stimulus pushes
// expected results into per-instance queues; a forked monitor pops and compares
// on every done pulse. Expectations follow whichever build is compiled
// (SYSID_CHECKER_TS_CHECK_EN defined or not).
// -----------------------------------------------------------------------------
module tb_sysid_checker;

`ifdef SYSID_CHECKER_TS_CHECK_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1520001003;
    localparam int LAT0   = TS_EN ? 3 : 2;   // done after start, L=0
    localparam int LAT2   = TS_EN ? 7 : 4;   // done after start, L=2
    localparam int RDTS0  = TS_EN ? 1 : 0;   // address-1 read cycles, L=0
    localparam int RDTS2  = TS_EN ? 3 : 0;   // address-1 read cycles, L=2
    localparam int PERIOD = TS_EN ? 5 : 4;   // start-to-next-accept spacing, L=0

    typedef struct {
        logic [31:0] id_v;
        logic [31:0] ts_v;
        logic        id_ok;
        logic        ts_ok;
        logic [7:0]  err;
        int          stamp;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    logic        clock = 1'b0;
    logic        rst0_n, rst2_n, start0, start2;
    logic        addr0, read0, busy0, done0, idok0, tsok0;
    logic        addr2, read2, busy2, done2, idok2, tsok2;
    logic [31:0] rdata0, idv0, tsv0, rdata2, idv2, tsv2;
    logic [7:0]  err0, err2;
    logic [31:0] id_w0, ts_w0, id_w2, ts_w2;
    logic [31:0] p1, p2;
    logic [7:0]  exp_err0, exp_err2;

    int cyc = 0;
    int tests = 0;
    int failed = 0;
    int rdid0 = 0, rdts0 = 0, rdid2 = 0, rdts2 = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Slave models.
    assign rdata0 = addr0 ? ts_w0 : id_w0;
    always @(posedge clock) begin
        p1 <= read2 ? (addr2 ? ts_w2 : id_w2) : 32'hDEAD_BEEF;
        p2 <= p1;
    end
    assign rdata2 = p2;

    sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0)) dut0 (
        .clock(clock), .reset_n(rst0_n), .start(start0),
        .sysid_address(addr0), .sysid_read(read0), .sysid_readdata(rdata0),
        .busy(busy0), .done(done0), .id_ok(idok0), .ts_ok(tsok0),
        .id_value(idv0), .ts_value(tsv0), .err_count(err0));

    sysid_checker #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2)) dut2 (
        .clock(clock), .reset_n(rst2_n), .start(start2),
        .sysid_address(addr2), .sysid_read(read2), .sysid_readdata(rdata2),
        .busy(busy2), .done(done2), .id_ok(idok2), .ts_ok(tsok2),
        .id_value(idv2), .ts_value(tsv2), .err_count(err2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] idw, input logic [31:0] tsw,
                                      input logic [7:0] err_before, input int stamp);
        exp_t e;
        e.id_v  = idw;
        e.ts_v  = TS_EN ? tsw : 32'd0;
        e.id_ok = (idw == EXP_ID);
        e.ts_ok = TS_EN ? (tsw == EXP_TS) : 1'b1;
        e.err   = ((!e.id_ok || !e.ts_ok) && (err_before != 8'd255)) ? err_before + 8'd1 : err_before;
        e.stamp = stamp;
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e,
                                input logic [31:0] idv, input logic [31:0] tsv,
                                input logic idok, input logic tsok, input logic bsy,
                                input logic [7:0] err, input int lat, input int lat_exp,
                                input int rdid, input int rdid_exp, input int rdts, input int rdts_exp);
        chk({tag, "_id_value"},  idv, e.id_v);
        chk({tag, "_ts_value"},  tsv, e.ts_v);
        chk({tag, "_id_ok"},     32'(idok), 32'(e.id_ok));
        chk({tag, "_ts_ok"},     32'(tsok), 32'(e.ts_ok));
        chk({tag, "_err_count"}, 32'(err), 32'(e.err));
        chk({tag, "_busy_in_done"}, 32'(bsy), 32'd0);
        chk({tag, "_done_latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_rd_addr0_cycles"}, 32'(rdid), 32'(rdid_exp));
        chk({tag, "_rd_addr1_cycles"}, 32'(rdts), 32'(rdts_exp));
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!rst0_n) begin
                q0.delete(); rdid0 = 0; rdts0 = 0;
            end else begin
                if (read0 && !addr0) rdid0++;
                if (read0 && addr0) rdts0++;
                if (done0) begin
                    if (q0.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL dut0_spurious_done: got done=1 expected done=0");
                    end else begin
                        e = q0.pop_front();
                        check_result("dut0", e, idv0, tsv0, idok0, tsok0, busy0, err0,
                                     cyc - e.stamp, LAT0, rdid0, 1, rdts0, RDTS0);
                    end
                    rdid0 = 0; rdts0 = 0;
                end
            end
            if (!rst2_n) begin
                q2.delete(); rdid2 = 0; rdts2 = 0;
            end else begin
                if (read2 && !addr2) rdid2++;
                if (read2 && addr2) rdts2++;
                if (done2) begin
                    if (q2.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL dut2_spurious_done: got done=1 expected done=0");
                    end else begin
                        e = q2.pop_front();
                        check_result("dut2", e, idv2, tsv2, idok2, tsok2, busy2, err2,
                                     cyc - e.stamp, LAT2, rdid2, 3, rdts2, RDTS2);
                    end
                    rdid2 = 0; rdts2 = 0;
                end
            end
        end
    endtask

    // Drive start for one cycle; push an expectation when this start is accepted.
    task automatic drive0(input bit s, input bit accept);
        exp_t e;
        start0 = s;
        if (accept) begin
            e = make_exp(id_w0, ts_w0, exp_err0, cyc + 1);
            exp_err0 = e.err;
            q0.push_back(e);
        end
        @(negedge clock);
        start0 = 1'b0;
    endtask

    task automatic drive2(input bit s, input bit accept);
        exp_t e;
        start2 = s;
        if (accept) begin
            e = make_exp(id_w2, ts_w2, exp_err2, cyc + 1);
            exp_err2 = e.err;
            q2.push_back(e);
        end
        @(negedge clock);
        start2 = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if ((q0.size() == 0) && (q2.size() == 0)) break;
            @(negedge clock);
        end
        chk("pending_dut0_results", 32'(q0.size()), 32'd0);
        chk("pending_dut2_results", 32'(q2.size()), 32'd0);
        @(negedge clock);
    endtask

    task automatic check_zero0();
        chk("rst0_flags", 32'({read0, addr0, busy0, done0, idok0, tsok0}), 32'd0);
        chk("rst0_id_value", idv0, 32'd0);
        chk("rst0_ts_value", tsv0, 32'd0);
        chk("rst0_err_count", 32'(err0), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0_n = 1'b0; rst2_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
        id_w0 = EXP_ID; ts_w0 = EXP_TS; id_w2 = EXP_ID; ts_w2 = EXP_TS;
        exp_err0 = 8'd0; exp_err2 = 8'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);

        // Reset state of both instances.
        check_zero0();
        chk("rst2_flags", 32'({read2, addr2, busy2, done2, idok2, tsok2}), 32'd0);
        chk("rst2_err_count", 32'(err2), 32'd0);
        rst0_n = 1'b1; rst2_n = 1'b1;
        @(negedge clock);

        // Matching words, L=0.
        drive0(1'b1, 1'b1);
        chk("busy_after_start", 32'(busy0), 32'd1);
        chk("read_after_start", 32'(read0), 32'd1);
        chk("addr_first_phase", 32'(addr0), 32'd0);
        wait_drain();

        // Timestamp off by one.
        ts_w0 = 32'd1520001004;
        drive0(1'b1, 1'b1);
        wait_drain();
        ts_w0 = EXP_TS;
        chk("err_after_ts_bad", 32'(err0), TS_EN ? 32'd1 : 32'd0);

        // Wrong ID.
        id_w0 = 32'h1234_5678;
        drive0(1'b1, 1'b1);
        wait_drain();
        chk("err_after_id_bad", 32'(err0), TS_EN ? 32'd2 : 32'd1);

        // 300 failing checks saturate the counter.
        id_w0 = 32'd1;
        for (int n = 0; n < 300; n++) begin
            drive0(1'b1, 1'b1);
            wait_drain();
        end
        chk("err_saturated", 32'(err0), 32'd255);
        id_w0 = EXP_ID;
        drive0(1'b1, 1'b1);
        wait_drain();
        chk("err_held_at_max", 32'(err0), 32'd255);
        chk("id_ok_after_good", 32'(idok0), 32'd1);

        // Start re-pulsed in RD_ID and DONE (dropped), back-to-back accept in
        // the first IDLE cycle after DONE, then a drop in the new RD_ID.
        for (int i = 0; i <= PERIOD + 1; i++) begin
            drive0((i == 0) || (i == 1) || (i == PERIOD - 1) || (i == PERIOD) || (i == PERIOD + 1),
                   (i == 0) || (i == PERIOD));
        end
        wait_drain();

        // Reset in the second read phase aborts the check.
        drive0(1'b1, 1'b0);
        drive0(1'b0, 1'b0);
        rst0_n = 1'b0;
        exp_err0 = 8'd0;
        @(negedge clock);
        check_zero0();
        @(negedge clock);
        rst0_n = 1'b1;
        drive0(1'b1, 1'b1);
        wait_drain();
        chk("err_after_reset_run", 32'(err0), 32'd0);

        // READ_LATENCY=2 instance.
        drive2(1'b1, 1'b1);
        wait_drain();
        ts_w2 = EXP_TS + 32'd1;
        drive2(1'b1, 1'b1);
        wait_drain();
        chk("dut2_err_after_ts_bad", 32'(err2), TS_EN ? 32'd1 : 32'd0);
        id_w2 = 32'hCAFE_0001;
        ts_w2 = EXP_TS;
        drive2(1'b1, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
